// File: rtl/pri_encoder_seq_if.sv
// Handshake bundle for pri_encoder_seq: request vector in, set-bit indices out.
// The slave modport is the encoder, the master modport is its environment.
interface pri_encoder_seq_if #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_idx, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_idx, out_valid, out_last
  );
endinterface

// File: rtl/pri_encoder_seq.sv
// Sequential priority encoder: accepts a WIDTH-bit request vector and emits
// the index of every set bit, one per output handshake, flagging the last.
// Build option PRI_ENC_MSB_FIRST_EN: when defined, indices are emitted
// highest-first; otherwise lowest-first.
module pri_encoder_seq #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  pri_encoder_seq_if.slave    bus
);
  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             is_last;
  logic             out_valid;
  logic             in_ready;
  logic             out_fire;
  logic             in_fire;

  // Pick the next index to emit from the pending bits.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
`ifdef PRI_ENC_MSB_FIRST_EN
      if (pend_q[WIDTH-1-i] && !sel_found) begin
        sel_idx   = IDX_W'(WIDTH - 1 - i);
        sel_found = 1'b1;
      end
`else
      if (pend_q[i] && !sel_found) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
`endif
    end
  end

  // Exactly one pending bit means the current index is the final one.
  always_comb begin
    is_last = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);
  end

  // Handshake qualifiers and outputs derived from registered state.
  always_comb begin
    out_valid = (state_q == ST_SCAN);
    out_fire  = out_valid & bus.out_ready;
    in_ready  = enable & ~reset & ((state_q == ST_IDLE) | (out_fire & is_last));
    in_fire   = bus.in_valid & in_ready;

    bus.out_valid = out_valid;
    bus.out_idx   = sel_idx;
    bus.out_last  = out_valid & is_last;
    bus.in_ready  = in_ready;
  end

  // Next-state: retire the emitted bit, then let a same-cycle accept reload.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (out_fire) begin
      pend_d[sel_idx] = 1'b0;
      if (is_last) begin
        state_d = ST_IDLE;
      end
    end
    if (in_fire) begin
      if (bus.in_data != '0) begin
        pend_d  = bus.in_data;
        state_d = ST_SCAN;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end
endmodule
